// File: rtl/i2s_output.sv
// Philips I2S transmitter: serializes one latched mono sample into both slots of each frame.
// BitClock and WordSelect are generated from Clock; SerialData changes on BitClock falling.
module i2s_output #(
    parameter int CLOCK_DIV     = 4,
    parameter int DATA_WIDTH    = 24,
    parameter int SLOT_WIDTH    = 32,
    parameter int OFFSET_BINARY = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic [DATA_WIDTH-1:0] Waveform,
    output logic                  BitClock,
    output logic                  WordSelect,
    output logic                  SerialData,
    output logic                  SampleTaken
);
    localparam int DIV_W     = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
    localparam int FRAME_LEN = 2 * SLOT_WIDTH;
    localparam int F_W       = $clog2(FRAME_LEN);
    localparam int IDX_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLOCK_DIV - 1);
    localparam logic [F_W-1:0]        F_LAST   = F_W'(FRAME_LEN - 1);
    localparam logic [F_W-1:0]        SLOT_LEN = F_W'(SLOT_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MSB_FLIP =
        (OFFSET_BINARY != 0) ? (DATA_WIDTH'(1) << (DATA_WIDTH - 1)) : '0;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_reg, state_next;
    logic [DIV_W-1:0]      div_reg, div_next;
    logic [F_W-1:0]        f_reg, f_next;
    logic                  bclk_reg, bclk_next;
    logic                  ws_reg, ws_next;
    logic                  sd_reg, sd_next;
    logic                  taken_reg, taken_next;
    logic [DATA_WIDTH-1:0] sample_reg, sample_next;

    logic [F_W-1:0]        pos;
    logic [IDX_W-1:0]      bit_idx;

    always_comb begin
        state_next  = state_reg;
        div_next    = div_reg;
        f_next      = f_reg;
        bclk_next   = bclk_reg;
        ws_next     = ws_reg;
        sd_next     = sd_reg;
        taken_next  = 1'b0;
        sample_next = sample_reg;
        pos         = '0;
        bit_idx     = '0;

        if (!Enable) begin
            state_next  = IDLE;
            div_next    = '0;
            f_next      = F_LAST;
            bclk_next   = 1'b0;
            ws_next     = 1'b1;
            sd_next     = 1'b0;
            sample_next = '0;
        end else if (state_reg == IDLE) begin
            // The enabling edge only arms the divider, so BitClock rises CLOCK_DIV edges later.
            state_next = RUN;
        end else begin
            div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
            if (div_reg == DIV_LAST) begin
                bclk_next = ~bclk_reg;
                if (bclk_reg) begin
                    f_next  = (f_reg == F_LAST) ? '0 : f_reg + 1'b1;
                    ws_next = (f_next >= SLOT_LEN);
                    pos     = ws_next ? (f_next - SLOT_LEN) : f_next;
                    bit_idx = IDX_W'(DATA_WIDTH - int'(pos));
                    // Position 0 is the one-bit I2S delay; positions past the sample pad with zeros.
                    sd_next = (pos != '0 && int'(pos) <= DATA_WIDTH) ? sample_reg[bit_idx] : 1'b0;
                    if (f_next == '0) begin
                        sample_next = Waveform ^ MSB_FLIP;
                        taken_next  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg  <= IDLE;
            div_reg    <= '0;
            f_reg      <= F_LAST;
            bclk_reg   <= 1'b0;
            ws_reg     <= 1'b1;
            sd_reg     <= 1'b0;
            taken_reg  <= 1'b0;
            sample_reg <= '0;
        end else begin
            state_reg  <= state_next;
            div_reg    <= div_next;
            f_reg      <= f_next;
            bclk_reg   <= bclk_next;
            ws_reg     <= ws_next;
            sd_reg     <= sd_next;
            taken_reg  <= taken_next;
            sample_reg <= sample_next;
        end
    end

    assign BitClock    = bclk_reg;
    assign WordSelect  = ws_reg;
    assign SerialData  = sd_reg;
    assign SampleTaken = taken_reg;
endmodule

// File: tb/tb_i2s_output.sv
// Scoreboard bench for i2s_output: three configurations (defaults, raw samples, CLOCK_DIV=1)
// run side by side, each with its own stimulus process and I2S receiver monitor.
module tb_i2s_output;
    localparam int DW   = 24;
    localparam int S    = 32;
    localparam int NCFG = 3;

    logic clk = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int cfg, input string name, input logic [63:0] actual,
                         input logic [63:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("FAIL cfg%0d %s: got 0x%0h, want 0x%0h", cfg, name, actual, required);
        end
    endtask

    task automatic flag(input int cfg, input string name);
        vectors++;
        miscompares++;
        $display("FAIL cfg%0d %s: output present with nothing expected", cfg, name);
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < NCFG; gi++) begin : g_cfg
            localparam int CD = (gi == 2) ? 1 : 4;
            localparam int OB = (gi == 1) ? 0 : 1;
            localparam int FL = 4 * S * CD;

            logic          rst  = 1'b1;
            logic          en   = 1'b0;
            logic [DW-1:0] wave = '0;
            logic          bclk, ws, sd, st;
            logic [S:0]    slot_q[$];
            int            st_q[$];

            i2s_output #(
                .CLOCK_DIV(CD), .DATA_WIDTH(DW), .SLOT_WIDTH(S), .OFFSET_BINARY(OB)
            ) u_dut (
                .Clock(clk), .Reset(rst), .Enable(en), .Waveform(wave),
                .BitClock(bclk), .WordSelect(ws), .SerialData(sd), .SampleTaken(st)
            );

            // Receiver: capture SerialData on each BitClock rise, restart a slot on a WordSelect change.
            initial begin
                logic         bclk_prev;
                logic         mon_ws;
                int           mon_cnt;
                logic [S-1:0] mon_bits;
                int           last_rise;
                logic [S:0]   exp_slot;
                int           exp_cyc;
                bclk_prev = 1'b0;
                mon_ws    = 1'b1;
                mon_cnt   = 0;
                mon_bits  = '0;
                last_rise = -1;
                forever begin
                    @(negedge clk);
                    if (bclk && !bclk_prev) begin
                        if (ws != mon_ws) begin
                            mon_cnt = 0;
                            mon_ws  = ws;
                        end
                        mon_bits = {mon_bits[S-2:0], sd};
                        mon_cnt++;
                        if (mon_cnt == S) begin
                            mon_cnt = 0;
                            if (slot_q.size() == 0) flag(gi, "slot_unexpected");
                            else begin
                                exp_slot = slot_q.pop_front();
                                check(gi, "slot", 64'({mon_ws, mon_bits}), 64'(exp_slot));
                            end
                        end
                        if (en && last_rise >= 0)
                            check(gi, "bclk_period", 64'(cyc - last_rise), 64'(2 * CD));
                        last_rise = cyc;
                    end
                    if (!en) last_rise = -1;
                    bclk_prev = bclk;
                    if (st) begin
                        if (st_q.size() == 0) flag(gi, "sample_taken_unexpected");
                        else begin
                            exp_cyc = st_q.pop_front();
                            check(gi, "sample_taken_cycle", 64'(cyc), 64'(exp_cyc));
                        end
                        check(gi, "sample_taken_ws", 64'(ws), 64'(0));
                        check(gi, "sample_taken_sd", 64'(sd), 64'(0));
                    end
                end
            end

            // Stimulus and reference model: timing and slot contents derived from edge counts.
            initial begin
                logic [DW-1:0] preset[$];
                logic [DW-1:0] samp;
                logic [S-1:0]  slot_bits;
                int            nf, stop_f, total, fr;

                if (gi == 0) begin
                    preset.push_back(24'hFFFFFF);
                    preset.push_back(24'h800000);
                    preset.push_back(24'h123456);
                end else if (gi == 1) preset.push_back(24'hA5A5A5);
                else preset.push_back(24'hFFFFFF);
                wave = preset.pop_front();

                repeat (2) @(negedge clk);
                check(gi, "reset_bclk", 64'(bclk), 64'(0));
                check(gi, "reset_ws",   64'(ws),   64'(1));
                check(gi, "reset_sd",   64'(sd),   64'(0));
                check(gi, "reset_st",   64'(st),   64'(0));
                rst = 1'b0;
                repeat (2) @(negedge clk);

                // Run 0 ends with Enable dropped at f=40, run 1 with Reset asserted at f=20.
                for (int r = 0; r < 2; r++) begin
                    nf     = (r == 0) ? 3 : 2;
                    stop_f = (r == 0) ? 40 : 20;
                    total  = 2 * CD + nf * FL + stop_f * 2 * CD;
                    en     = 1'b1;
                    for (int n = 0; n <= total; n++) begin
                        if (n >= 2 * CD && (n - 2 * CD) % FL == 0) begin
                            fr        = (n - 2 * CD) / FL;
                            samp      = (OB != 0) ? wave + 24'h800000 : wave;
                            slot_bits = S'(samp) << (S - 1 - DW);
                            st_q.push_back(cyc + 1);
                            if (fr < nf || stop_f >= S) slot_q.push_back({1'b0, slot_bits});
                            if (fr < nf) slot_q.push_back({1'b1, slot_bits});
                        end
                        if (n >= 2 * CD && (n - 2 * CD) % FL == 20 * CD)
                            wave = (preset.size() > 0) ? preset.pop_front() : DW'($urandom);
                        @(negedge clk);
                    end
                    if (r == 0) begin
                        en = 1'b0;
                        @(negedge clk);
                        check(gi, "abort_bclk", 64'(bclk), 64'(0));
                        check(gi, "abort_ws",   64'(ws),   64'(1));
                        check(gi, "abort_sd",   64'(sd),   64'(0));
                        check(gi, "abort_st",   64'(st),   64'(0));
                    end else begin
                        check(gi, "pre_reset_ws", 64'(ws), 64'(0));
                        rst = 1'b1;
                        en  = 1'b0;
                        #1;
                        check(gi, "async_reset_bclk", 64'(bclk), 64'(0));
                        check(gi, "async_reset_ws",   64'(ws),   64'(1));
                        check(gi, "async_reset_sd",   64'(sd),   64'(0));
                        check(gi, "async_reset_st",   64'(st),   64'(0));
                        repeat (3) @(negedge clk);
                        rst = 1'b0;
                    end
                    repeat (6) @(negedge clk);
                end

                check(gi, "slots_outstanding",  64'(slot_q.size()), 64'(0));
                check(gi, "samples_outstanding", 64'(st_q.size()),  64'(0));
                done_cnt++;
            end
        end
    endgenerate

    initial begin
        for (int c = 0; c < 40000 && done_cnt < NCFG; c++) @(negedge clk);
        if (done_cnt < NCFG) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: %0d of %0d configurations finished", done_cnt, NCFG);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
